// File: rtl/riscv_pkg.sv
// riscv_pkg: shared widths, register-file constants and result-select encodings for the writeback stage.
package riscv_pkg;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10,
    RES_IMM = 2'b11
  } res_src_e;
endpackage

// File: rtl/writeback_regfile_if.sv
// writeback_regfile_if: MEM/WB fields, decode read ports and writeback observation signals.
interface writeback_regfile_if;
  import riscv_pkg::*;
  logic              regWriteW;
  logic [1:0]        resultSrcW;
  logic [ADDR_W-1:0] RdW;
  logic [XLEN-1:0]   ALUResultW;
  logic [XLEN-1:0]   ReadDataW;
  logic [XLEN-1:0]   PCPlus4W;
  logic [XLEN-1:0]   extImmW;
  logic [ADDR_W-1:0] Rs1D;
  logic [ADDR_W-1:0] Rs2D;
  logic [XLEN-1:0]   RD1D;
  logic [XLEN-1:0]   RD2D;
  logic [XLEN-1:0]   ResultW;
  logic [31:0]       wbCount;
  modport master (
    output regWriteW, resultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, extImmW, Rs1D, Rs2D,
    input  RD1D, RD2D, ResultW, wbCount
  );
  modport slave (
    input  regWriteW, resultSrcW, RdW, ALUResultW, ReadDataW, PCPlus4W, extImmW, Rs1D, Rs2D,
    output RD1D, RD2D, ResultW, wbCount
  );
endinterface

// File: rtl/result_mux.sv
// result_mux: pure 4:1 writeback result select, shared with the forwarding unit.
module result_mux
  import riscv_pkg::*;
(
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] alu,
  input  logic [XLEN-1:0] mem,
  input  logic [XLEN-1:0] pc4,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] result
);
  always_comb begin
    result = sel == RES_ALU ? alu : sel == RES_MEM ? mem : sel == RES_PC4 ? pc4 : imm;
  end
endmodule

// File: rtl/writeback_regfile.sv
// writeback_regfile: RV32I writeback select, x1..x31 register file, two async read ports, commit counter.
// Define WB_BYPASS_EN to make same-cycle reads of the register being committed return ResultW.
module writeback_regfile
  import riscv_pkg::*;
(
  input logic clk,
  input logic rst,
  writeback_regfile_if.slave bus
);
  logic [XLEN-1:0] regs [NREG];
  logic [31:0] count;
  logic commit, hit1, hit2;
  result_mux u_result_mux (
    .sel   (bus.resultSrcW),
    .alu   (bus.ALUResultW),
    .mem   (bus.ReadDataW),
    .pc4   (bus.PCPlus4W),
    .imm   (bus.extImmW),
    .result(bus.ResultW)
  );
  assign commit = bus.regWriteW && bus.RdW != REG_ZERO;
`ifdef WB_BYPASS_EN
  assign hit1 = commit && bus.Rs1D == bus.RdW;
  assign hit2 = commit && bus.Rs2D == bus.RdW;
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      count <= '0;
    end else if (commit) begin
      regs[bus.RdW] <= bus.ResultW;
      count <= count + 32'd1;
    end
  end
  // x0 is forced to zero on read, so its array slot is never consulted
  always_comb begin
    bus.RD1D = bus.Rs1D == REG_ZERO ? '0 : hit1 ? bus.ResultW : regs[bus.Rs1D];
    bus.RD2D = bus.Rs2D == REG_ZERO ? '0 : hit2 ? bus.ResultW : regs[bus.Rs2D];
    bus.wbCount = count;
  end
endmodule

// File: tb/tb_writeback_regfile.sv
// tb_writeback_regfile: directed vectors with a queued scoreboard checked by a negedge monitor.
module tb_writeback_regfile;
  typedef enum int {S_RD1, S_RD2, S_RES, S_CNT} sig_e;
  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } exp_t;

  logic clk = 0;
  logic rst = 0;
  int vectors = 0;
  int miscompares = 0;
  int cnt = 0;
  exp_t q[$];
  writeback_regfile_if bus ();

  writeback_regfile dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [31:0] actual(sig_e s);
    return s == S_RD1 ? bus.RD1D : s == S_RD2 ? bus.RD2D : s == S_RES ? bus.ResultW : bus.wbCount;
  endfunction

  initial begin
    exp_t e;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      while (q.size() > 0) begin
        e = q.pop_front();
        a = actual(e.sig);
        vectors++;
        if (a !== e.exp) begin
          miscompares++;
          $display("FAIL %s: got %h expected %h", e.name, a, e.exp);
        end
      end
    end
  end

  task automatic expect_val(string name, sig_e s, logic [31:0] v);
    exp_t e;
    e.name = name;
    e.sig = s;
    e.exp = v;
    q.push_back(e);
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() > 0 && n < 5) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d checks pending expected 0", q.size());
      q.delete();
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic commit(logic [4:0] rd, logic [31:0] val);
    bus.regWriteW = 1;
    bus.resultSrcW = 2'b00;
    bus.RdW = rd;
    bus.ALUResultW = val;
    next_cycle();
    bus.regWriteW = 0;
    if (rd != 0) cnt++;
  endtask

  initial begin
    logic [31:0] tbl [4];
    logic [31:0] exp5;
    tbl[0] = 32'h11; tbl[1] = 32'h22; tbl[2] = 32'h33; tbl[3] = 32'h44;
    bus.regWriteW = 0; bus.resultSrcW = 0; bus.RdW = 0;
    bus.ALUResultW = 0; bus.ReadDataW = 0; bus.PCPlus4W = 0; bus.extImmW = 0;
    bus.Rs1D = 0; bus.Rs2D = 0;
    repeat (2) next_cycle();
    // reset holds every read port at zero
    for (int i = 0; i < 32; i++) begin
      bus.Rs1D = 5'(i);
      bus.Rs2D = 5'(31 - i);
      expect_val("reset_rd1", S_RD1, 0);
      expect_val("reset_rd2", S_RD2, 0);
      drain();
    end
    expect_val("reset_cnt", S_CNT, 0);
    drain();
    next_cycle();
    rst = 1;
    for (int i = 1; i < 32; i += 10) begin
      bus.Rs1D = 5'(i);
      bus.Rs2D = 5'(i + 1);
      expect_val("post_reset_rd1", S_RD1, 0);
      expect_val("post_reset_rd2", S_RD2, 0);
      expect_val("post_reset_cnt", S_CNT, 0);
      drain();
    end
    bus.ALUResultW = 32'h11; bus.ReadDataW = 32'h22; bus.PCPlus4W = 32'h33; bus.extImmW = 32'h44;
    for (int s = 0; s < 4; s++) begin
      bus.resultSrcW = 2'(s);
      expect_val("result_sel", S_RES, tbl[s]);
      drain();
    end
    next_cycle();
    expect_val("noop_cnt", S_CNT, 0);
    drain();
    commit(5, 32'hDEADBEEF);
    bus.Rs1D = 5;
    expect_val("commit_rd1", S_RD1, 32'hDEADBEEF);
    expect_val("commit_cnt", S_CNT, cnt);
    drain();
    bus.regWriteW = 1; bus.RdW = 0; bus.resultSrcW = 2'b11; bus.extImmW = 32'hFFFFFFFF;
    expect_val("x0_result", S_RES, 32'hFFFFFFFF);
    drain();
    next_cycle();
    bus.regWriteW = 0;
    bus.Rs1D = 0; bus.Rs2D = 0;
    expect_val("x0_rd1", S_RD1, 0);
    expect_val("x0_rd2", S_RD2, 0);
    expect_val("x0_cnt", S_CNT, cnt);
    drain();
    commit(7, 32'h1);
    bus.Rs1D = 7; bus.Rs2D = 7;
    bus.regWriteW = 1; bus.RdW = 7; bus.resultSrcW = 2'b00; bus.ALUResultW = 32'h2;
`ifdef WB_BYPASS_EN
    exp5 = 32'h2;
`else
    exp5 = 32'h1;
`endif
    expect_val("hazard_rd1", S_RD1, exp5);
    expect_val("hazard_rd2", S_RD2, exp5);
    drain();
    next_cycle();
    bus.regWriteW = 0;
    cnt++;
    expect_val("after_hazard_rd1", S_RD1, 32'h2);
    expect_val("after_hazard_rd2", S_RD2, 32'h2);
    expect_val("after_hazard_cnt", S_CNT, cnt);
    drain();
    commit(3, 32'h55);
    for (int r = 10; r < 15; r++) commit(5'(r), 32'(r));
    bus.Rs1D = 3; bus.Rs2D = 12;
    expect_val("pre_rst_rd1", S_RD1, 32'h55);
    expect_val("pre_rst_rd2", S_RD2, 32'd12);
    expect_val("pre_rst_cnt", S_CNT, 9);
    drain();
    // reset lands between edges while a commit to x3 is pending
    bus.regWriteW = 1; bus.RdW = 3; bus.ALUResultW = 32'hAA;
    rst = 0;
    expect_val("async_rst_rd1", S_RD1, 0);
    expect_val("async_rst_rd2", S_RD2, 0);
    expect_val("async_rst_cnt", S_CNT, 0);
    drain();
    next_cycle();
    expect_val("rst_edge_rd1", S_RD1, 0);
    expect_val("rst_edge_cnt", S_CNT, 0);
    drain();
    bus.regWriteW = 0;
    rst = 1;
    expect_val("rst_release_rd1", S_RD1, 0);
    expect_val("rst_release_cnt", S_CNT, 0);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
